wn_pdcchrx_frequencyoffset_avg: RTL and testbench

WN_PDCCHRX_FREQUENCYOFFSET_AVG -- requirements
Module: wn_pdcchrx_frequencyoffset_avg

---
 rtl/wn_pdcchrx_frequencyoffset_avg_if.sv | 23 ++
 rtl/wn_pdcchrx_frequencyoffset_avg.sv | 97 +++++++++
 tb/tb_wn_pdcchrx_frequencyoffset_avg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wn_pdcchrx_frequencyoffset_avg_if.sv
// wn_pdcchrx_frequencyoffset_avg_if: config, correlation-in and average-out AXI-Stream bundle
interface wn_pdcchrx_frequencyoffset_avg_if #(parameter int DW = 24, parameter int CW = 8);
    logic [CW-1:0]   config_in_tdata;
    logic            config_in_tvalid;
    logic            config_in_tready;
    logic [2*DW-1:0] data_in_tdata;
    logic            data_in_tvalid;
    logic            data_in_tready;
    logic            data_in_tlast;
    logic [2*DW-1:0] data_out_tdata;
    logic            data_out_tvalid;
    logic            data_out_tready;
    logic            data_out_tlast;
    logic [1:0]      data_out_tuser;
    modport slave (
        input  config_in_tdata, config_in_tvalid, data_in_tdata, data_in_tvalid, data_in_tlast, data_out_tready,
        output config_in_tready, data_in_tready, data_out_tdata, data_out_tvalid, data_out_tlast, data_out_tuser
    );
    modport master (
        output config_in_tdata, config_in_tvalid, data_in_tdata, data_in_tvalid, data_in_tlast, data_out_tready,
        input  config_in_tready, data_in_tready, data_out_tdata, data_out_tvalid, data_out_tlast, data_out_tuser
    );
endinterface

// File: rtl/wn_pdcchrx_frequencyoffset_avg.sv
// wn_pdcchrx_frequencyoffset_avg: accumulates N complex correlations, rounds, shifts and saturates the sum
module wn_pdcchrx_frequencyoffset_avg #(
    parameter int DW = 24,
    parameter int CW = 8
) (
    input logic clk,
    input logic rst,
    wn_pdcchrx_frequencyoffset_avg_if.slave io
);
    localparam int AW = DW + 4;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t state;
    logic signed [AW-1:0] acc_re, acc_im, sum_re, sum_im;
    logic [3:0] cnt, n_m1, shift;
    logic [DW:0] res_re, res_im;
    logic last_beat, mism, cfg_rdy, dat_rdy, out_valid, out_last;
    logic [2*DW-1:0] out_data;
    logic [1:0] out_user;
    // returns {saturated, value}; one extra bit keeps the rounding add from wrapping
    function automatic logic [DW:0] rnd_sat(input logic signed [AW-1:0] a, input logic [3:0] sh);
        logic signed [AW:0] r;
        logic sat;
        r = (AW+1)'(a) + ((sh == 4'd0) ? '0 : (AW+1)'(1) << (sh - 4'd1));
        r = r >>> sh;
        sat = !(&r[AW:DW-1] || !(|r[AW:DW-1]));
        return {sat, sat ? {r[AW], {(DW-1){~r[AW]}}} : r[DW-1:0]};
    endfunction
    always_comb begin
        sum_re = acc_re + AW'($signed(io.data_in_tdata[DW-1:0]));
        sum_im = acc_im + AW'($signed(io.data_in_tdata[2*DW-1:DW]));
        last_beat = io.data_in_tlast || cnt == n_m1;
        mism = io.data_in_tlast ^ (cnt == n_m1);
        res_re = rnd_sat(sum_re, shift);
        res_im = rnd_sat(sum_im, shift);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc_re <= '0;
            acc_im <= '0;
            cnt <= '0;
            n_m1 <= '0;
            shift <= '0;
            cfg_rdy <= 1'b0;
            dat_rdy <= 1'b0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
            out_user <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_rdy <= 1'b1;
                    if (cfg_rdy && io.config_in_tvalid) begin
                        n_m1 <= io.config_in_tdata[3:0];
                        shift <= io.config_in_tdata[7:4];
                        acc_re <= '0;
                        acc_im <= '0;
                        cnt <= '0;
                        cfg_rdy <= 1'b0;
                        dat_rdy <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (io.data_in_tvalid) begin
                        acc_re <= sum_re;
                        acc_im <= sum_im;
                        cnt <= cnt + 4'd1;
                        if (last_beat) begin
                            out_data <= {res_im[DW-1:0], res_re[DW-1:0]};
                            out_user <= {res_im[DW] | res_re[DW], mism};
                            out_valid <= 1'b1;
                            out_last <= 1'b1;
                            dat_rdy <= 1'b0;
                            state <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (io.data_out_tready) begin
                        out_valid <= 1'b0;
                        out_last <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign io.config_in_tready = cfg_rdy;
    assign io.data_in_tready = dat_rdy;
    assign io.data_out_tvalid = out_valid;
    assign io.data_out_tlast = out_last;
    assign io.data_out_tdata = out_data;
    assign io.data_out_tuser = out_user;
endmodule

// File: tb/tb_wn_pdcchrx_frequencyoffset_avg.sv
// tb_wn_pdcchrx_frequencyoffset_avg: scoreboard bench with throttled stimulus and output backpressure
module tb_wn_pdcchrx_frequencyoffset_avg;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    int exp_cnt = 0;
    bit thr = 0;
    bit bp = 0;
    logic [49:0] sb[$];
    logic [23:0] re_q[$];
    logic [23:0] im_q[$];
    always #5 clk = ~clk;
    wn_pdcchrx_frequencyoffset_avg_if #(.DW(24), .CW(8)) io ();
    wn_pdcchrx_frequencyoffset_avg #(.DW(24), .CW(8)) dut (.clk(clk), .rst(rst), .io(io));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [24:0] model(input longint sum, input int sh);
        longint r = sum;
        if (sh > 0) r += longint'(1) << (sh - 1);
        r = r >>> sh;
        if (r > 64'sd8388607) return {1'b1, 24'h7FFFFF};
        if (r < -64'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, r[23:0]};
    endfunction
    task automatic gap();
        if (thr) repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_rdy(input bit is_cfg);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                failures++;
                $display("FAIL handshake_timeout got=no_ready exp=ready");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1);
            end
        end while (!(is_cfg ? io.config_in_tready : io.data_in_tready));
        @(posedge clk);
        #1;
    endtask
    task automatic send_cfg(input int n, input int sh);
        logic [3:0] nm = 4'(n - 1);
        logic [3:0] s4 = 4'(sh);
        gap();
        io.config_in_tdata = {s4, nm};
        io.config_in_tvalid = 1'b1;
        wait_rdy(1'b1);
        io.config_in_tvalid = 1'b0;
    endtask
    task automatic send_beat(input logic [23:0] re, input logic [23:0] im, input bit lst);
        gap();
        io.data_in_tdata = {im, re};
        io.data_in_tlast = lst;
        io.data_in_tvalid = 1'b1;
        wait_rdy(1'b0);
        io.data_in_tvalid = 1'b0;
        io.data_in_tlast = 1'b0;
    endtask
    task automatic run_group(input int n, input int sh, input bit lst);
        longint sr = 0;
        longint si = 0;
        int beats = re_q.size();
        logic [24:0] mr, mi;
        bit mism;
        foreach (re_q[i]) begin
            sr += longint'($signed(re_q[i]));
            si += longint'($signed(im_q[i]));
        end
        mr = model(sr, sh);
        mi = model(si, sh);
        mism = (lst && beats < n) || (beats == n && !lst);
        sb.push_back({mr[24] | mi[24], mism, mi[23:0], mr[23:0]});
        exp_cnt++;
        send_cfg(n, sh);
        for (int b = 0; b < beats; b++) send_beat(re_q[b], im_q[b], lst && b == beats - 1);
        re_q.delete();
        im_q.delete();
    endtask
    task automatic fill(input int k, input logic [23:0] re, input logic [23:0] im);
        repeat (k) begin
            re_q.push_back(re);
            im_q.push_back(im);
        end
    endtask
    initial begin
        bit stall = 0;
        logic [50:0] held = '0;
        logic [49:0] e;
        forever begin
            @(negedge clk);
            if (rst) stall = 0;
            else begin
                if (stall) begin
                    chk("stall_valid", 64'(io.data_out_tvalid), 64'd1);
                    chk("stall_hold", 64'({io.data_out_tuser, io.data_out_tlast, io.data_out_tdata}), 64'(held));
                    chk("stall_in_rdy", 64'({io.config_in_tready, io.data_in_tready}), 64'd0);
                end
                if (io.data_out_tvalid && io.data_out_tready) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected got=%h exp=no_output", io.data_out_tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'({io.data_out_tuser, io.data_out_tdata}), 64'(e));
                        chk("out_last", 64'(io.data_out_tlast), 64'd1);
                    end
                end
                stall = io.data_out_tvalid && !io.data_out_tready;
                held = {io.data_out_tuser, io.data_out_tlast, io.data_out_tdata};
            end
        end
    end
    initial begin
        io.data_out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp) io.data_out_tready = 1'b1;
            else if ($urandom_range(0, 19) == 0) begin
                io.data_out_tready = 1'b0;
                repeat ($urandom_range(0, 100)) @(posedge clk);
            end else io.data_out_tready = $urandom_range(0, 2) != 0;
        end
    end
    initial begin
        int t = 0;
        rst = 1'b1;
        io.config_in_tdata = '0;
        io.config_in_tvalid = 1'b0;
        io.data_in_tdata = '0;
        io.data_in_tvalid = 1'b0;
        io.data_in_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'({io.config_in_tready, io.data_in_tready, io.data_out_tvalid, io.data_out_tlast,
            io.data_out_tuser, io.data_out_tdata}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_rdy_in_rst_cycle", 64'(io.config_in_tready), 64'd0);
        @(negedge clk);
        chk("cfg_rdy_after_rst", 64'(io.config_in_tready), 64'd1);
        chk("dat_rdy_idle", 64'(io.data_in_tready), 64'd0);
        @(posedge clk);
        #1;
        fill(4, 24'h000100, 24'hFFFF00);
        run_group(4, 2, 1'b1);
        fill(16, 24'h7FFFFF, 24'h000000);
        run_group(16, 0, 1'b1);
        fill(16, 24'h800000, 24'h000001);
        run_group(16, 0, 1'b1);
        fill(3, 24'h000010, 24'h000020);
        run_group(8, 0, 1'b1);
        re_q.push_back(24'h000003);
        im_q.push_back(24'hFFFFFD);
        fill(1, 24'h000000, 24'h000000);
        run_group(2, 1, 1'b1);
        fill(3, 24'h000005, 24'hFFFFF0);
        run_group(3, 1, 1'b0);
        fill(1, 24'h123456, 24'hEDCBA9);
        run_group(1, 0, 1'b1);
        send_cfg(4, 0);
        send_beat(24'h000111, 24'h000222, 1'b0);
        send_beat(24'h000111, 24'h000222, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_out", 64'(io.data_out_tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        fill(4, 24'h000008, 24'h000004);
        run_group(4, 2, 1'b1);
        thr = 1;
        bp = 1;
        for (int g = 0; g < 40; g++) begin
            int n = $urandom_range(1, 16);
            int sh = $urandom_range(0, 15);
            int mode = (n > 1) ? $urandom_range(0, 2) : 0;
            int beats = (mode == 1) ? $urandom_range(1, n - 1) : n;
            bit big = $urandom_range(0, 3) == 0;
            for (int b = 0; b < beats; b++) begin
                re_q.push_back(big ? (($urandom_range(0, 1) != 0) ? 24'h7FFF00 : 24'h800100) : 24'($urandom));
                im_q.push_back(24'($urandom));
            end
            run_group(n, sh, mode != 2);
        end
        while (sb.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("out_count", 64'(out_cnt), 64'(exp_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
